// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: issues word-aligned fetches and buffers in-order responses for decode.
// Optional FETCH_BYPASS_EN lets a response reach decode in its arrival cycle when the queue is empty.
module fetch_queue_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic                     imem_req_o,
    output logic [XLEN-1:0]          imem_addr_o,
    input  logic                     imem_gnt_i,
    input  logic                     imem_rvalid_i,
    input  logic [31:0]              imem_rdata_i,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [31:0]              id_instr_o,
    output logic [XLEN-1:0]          id_pc_o,
    input  logic                     redirect_i,
    input  logic [XLEN-1:0]          redirect_pc_i,
    output logic [$clog2(DEPTH):0]   fq_count_o
);
    // state | meaning
    // IDLE  | fetch disabled, no request on the bus
    // RUN   | issuing requests while credit allows; leaves once start_i drops and nothing is pending
    typedef enum logic {IDLE, RUN} state_t;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned KW = AW + 3;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, resp_pc_q;
    logic            req_pend_q;
    logic [CW-1:0]   count_q, outst_q;
    logic [KW-1:0]   kill_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];

    logic [CW:0]     inflight;
    logic            credit_ok, req, grant;
    logic            resp_kill, resp_take, accept, head_valid, byp_valid;
    logic            valid, pop, byp_take, push;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign inflight     = {1'b0, count_q} + {1'b0, outst_q};
    assign credit_ok    = inflight < (CW+1)'(DEPTH);
    // Once a request is on the bus it stays there until granted, even if start_i drops.
    assign req          = (state_q == RUN) && !redirect_i && (req_pend_q || (start_i && credit_ok));
    assign grant        = req && imem_gnt_i;

    assign resp_kill  = imem_rvalid_i && (kill_q != '0);
    assign resp_take  = imem_rvalid_i && (kill_q == '0) && (outst_q != '0);
    assign accept     = resp_take && !redirect_i;
    assign head_valid = (count_q != '0);

    always_comb begin
        byp_valid = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp_valid = accept && !head_valid;
`endif
    end

    assign valid    = rst_i && !redirect_i && (head_valid || byp_valid);
    assign pop      = valid && id_ready_i && head_valid;
    assign byp_take = valid && id_ready_i && byp_valid;
    assign push     = accept && !byp_take;

    always_comb begin
        id_instr_o = '0;
        id_pc_o    = '0;
        if (rst_i) begin
            if (head_valid) begin
                id_instr_o = instr_mem[rd_ptr_q];
                id_pc_o    = pc_mem[rd_ptr_q];
            end else if (byp_valid) begin
                id_instr_o = imem_rdata_i;
                id_pc_o    = resp_pc_q;
            end
        end
    end

    assign id_valid_o  = valid;
    assign imem_req_o  = rst_i && req;
    assign imem_addr_o = rst_i ? fetch_pc_q : RESET_PC;
    assign fq_count_o  = count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (!start_i && !req_pend_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            req_pend_q <= 1'b0;
            count_q    <= '0;
            outst_q    <= '0;
            kill_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_i) begin
                // Everything still in flight, plus a grant landing now, must be dropped on return.
                fetch_pc_q <= redirect_tgt;
                resp_pc_q  <= redirect_tgt;
                req_pend_q <= 1'b0;
                count_q    <= '0;
                outst_q    <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                kill_q     <= kill_q - KW'(resp_kill) + KW'(outst_q) - KW'(resp_take)
                              + KW'(imem_gnt_i);
            end else begin
                req_pend_q <= req && !imem_gnt_i;
                if (grant) fetch_pc_q <= fetch_pc_q + XLEN'(4);
                if (accept) resp_pc_q <= resp_pc_q + XLEN'(4);
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
                outst_q <= outst_q + CW'(grant) - CW'(resp_take);
                kill_q  <= kill_q - KW'(resp_kill);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata_i;
            pc_mem[wr_ptr_q]    <= resp_pc_q;
        end
    end
endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and address width.
REQ-002 SHALL have parameter DEPTH, default 4: fetch-queue entries; power of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 SHALL have port clk_i  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port start_i  input  1: fetch enable; new requests are issued only while high.
REQ-007 SHALL have port imem_req_o  output  1: instruction-memory request valid.
REQ-008 SHALL have port imem_addr_o  output  XLEN: request address, word-aligned.
REQ-009 SHALL have port imem_gnt_i  input  1: request accepted this cycle.
REQ-010 SHALL have port imem_rvalid_i  input  1: response valid; responses return in request order, at least 1 cycle after grant.
REQ-011 SHALL have port imem_rdata_i  input  32: response instruction word.
REQ-012 SHALL have port id_valid_o  output  1: instruction available to decode.
REQ-013 SHALL have port id_ready_i  input  1: decode accepts; transfer occurs when id_valid_o and id_ready_i are both high.
REQ-014 SHALL have port id_instr_o  output  32: instruction presented to decode.
REQ-015 SHALL have port id_pc_o  output  XLEN: PC of id_instr_o.
REQ-016 SHALL have port redirect_i  input  1: branch or flush redirect strobe.
REQ-017 SHALL have port redirect_pc_i  input  XLEN: redirect target address.
REQ-018 SHALL have port fq_count_o  output  clog2(DEPTH)+1: current queue occupancy.

Function
REQ-019 SHALL implement a two-state FSM, IDLE and RUN; IDLE goes to RUN when start_i=1, and RUN goes to IDLE when start_i=0 and no request is pending.
REQ-020 SHALL assert imem_req_o only in RUN, when no redirect_i is present that cycle, and when queue count + outstanding < DEPTH.
REQ-021 SHALL hold imem_req_o and imem_addr_o stable until imem_gnt_i; on grant, the fetch PC advances by 4 (modulo 2^XLEN) and outstanding increments.
REQ-022 SHALL pair each accepted response with its request PC and write both to the queue tail; outstanding decrements on each response.
REQ-023 SHALL present the queue head on id_valid_o, id_instr_o and id_pc_o; the head pops on transfer.
REQ-024 SHALL latch fetch PC = {redirect_pc_i[XLEN-1:2],2'b00} on redirect_i, empty the queue, and load kill counter = outstanding plus 1 if imem_gnt_i is high that same cycle.
REQ-025 SHALL discard responses while kill counter is nonzero, decrementing it by 1 per discarded response, and SHALL NOT write discarded responses to the queue.
REQ-026 SHALL give redirect_i priority over push and pop in the same cycle, and SHALL force id_valid_o low during the redirect cycle.
REQ-027 SHALL update count correctly on a same-cycle push and pop, including when the queue is full; the credit rule in REQ-020 makes overflow impossible.
REQ-028 SHALL ignore a response arriving when outstanding=0 and kill counter=0 (protocol error), leaving the queue unchanged.
REQ-029 SHALL issue the first request no earlier than the cycle after RUN is entered; fetch-to-decode latency is 1 cycle from the response, or 0 cycles per REQ-033.

Reset
REQ-030 SHALL, when rst_i=0 at a rising edge: set state IDLE, fetch PC RESET_PC, and queue, outstanding and kill counter all to 0.
REQ-031 SHALL hold imem_req_o=0, id_valid_o=0, fq_count_o=0, id_instr_o=0, id_pc_o=0 and imem_addr_o=RESET_PC while in reset.
REQ-032 SHALL, when reset is taken mid-operation, drop in-flight requests silently; the memory side is reset together with this block.

Configuration
REQ-033 SHALL, with FETCH_BYPASS_EN defined, present a non-discarded response on id_*_o in the same cycle when the queue is empty, consuming it without a write if id_ready_i=1 and writing it to the queue otherwise.
REQ-034 SHALL, without FETCH_BYPASS_EN, always write responses to the queue, making them visible on the next cycle.

Verification
REQ-035 SHALL cover: reset released, start_i=1, gnt and rvalid 1 cycle later, id_ready_i=1 -> id_pc_o sequence 0,4,8,12 with matching instructions and no bubbles in steady state.
REQ-036 SHALL cover: DEPTH=4, id_ready_i=0 -> at most 4 grants, fq_count_o=4, imem_req_o low; one pop then allows exactly one new request.
REQ-037 SHALL cover: redirect_i to 0x103 with 2 outstanding plus a grant in the same cycle -> next imem_addr_o=0x100, 3 responses discarded, first id_pc_o=0x100.
REQ-038 SHALL cover: fetch PC at 0xFFFF_FFFC with XLEN=32 -> next request address 0x0000_0000.
REQ-039 SHALL cover: rst_i=0 asserted while queue holds 3 entries -> next cycle fq_count_o=0, id_valid_o=0, imem_addr_o=RESET_PC.
REQ-040 SHALL cover: FETCH_BYPASS_EN defined, empty queue, id_ready_i=1 -> id_valid_o high in the same cycle as imem_rvalid_i; undefined -> high exactly one cycle later.
